// File: rtl/float_add_seq.sv
// Multi-cycle binary32 adder: valid/ready operand accept, FSM-sequenced align,
// add and one-bit-per-cycle normalisation, registered result held until taken.
module float_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] add_res,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] ml_q, ml_d;
  logic [23:0] ms_q, ms_d;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic [7:0]  exp_a, exp_b, exp_l, exp_s, shamt;
  logic [23:0] man_a, man_b, man_l, man_s, ms_shift;
  logic        a_is_l, sign_l;
  logic [24:0] sum;
  logic [7:0]  exp_inc;

  assign exp_a   = opa_q[30:23];
  assign exp_b   = opb_q[30:23];
  assign man_a   = {1'b1, opa_q[22:0]};
  assign man_b   = {1'b1, opb_q[22:0]};
  // Magnitude order on {exp, fraction}; ties keep A as the larger operand.
  assign a_is_l  = (opa_q[30:0] >= opb_q[30:0]);
  assign exp_l   = a_is_l ? exp_a : exp_b;
  assign exp_s   = a_is_l ? exp_b : exp_a;
  assign man_l   = a_is_l ? man_a : man_b;
  assign man_s   = a_is_l ? man_b : man_a;
  assign sign_l  = a_is_l ? opa_q[31] : opb_q[31];
  assign shamt   = exp_l - exp_s;
  assign ms_shift = (shamt >= 8'd24) ? '0 : (man_s >> shamt);

  assign sum     = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q})
                         : ({1'b0, ml_q} + {1'b0, ms_q});
  assign exp_inc = exp_q + 8'd1;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    ml_d    = ml_q;
    ms_d    = ms_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d   = operand_A;
          opb_d   = operand_B;
          state_d = S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (exp_a == 8'hFF || exp_b == 8'hFF) begin
          res_d   = 32'h7FC0_0000;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else if (exp_a == 8'd0 && exp_b == 8'd0) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else if (exp_a == 8'd0) begin
          res_d   = opb_q;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else if (exp_b == 8'd0) begin
          res_d   = opa_q;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          sign_d  = sign_l;
          sub_d   = opa_q[31] ^ opb_q[31];
          exp_d   = exp_l;
          ml_d    = man_l;
          ms_d    = ms_shift;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        if (sum[24]) begin
          if (exp_inc == 8'hFF) begin
            res_d   = {sign_q, 8'hFF, 23'd0};
            ovf_d   = 1'b1;
            unf_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            exp_d   = exp_inc;
            ml_d    = sum[24:1];
            state_d = S_NORM;
          end
        end else if (sum == '0) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          ml_d    = sum[23:0];
          state_d = S_NORM;
        end
      end

      // ml_q holds the working mantissa from ADD onwards.
      S_NORM: begin
        if (ml_q[23]) begin
          res_d   = {sign_q, exp_q, ml_q[22:0]};
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else if (exp_q > 8'd1) begin
          ml_d    = {ml_q[22:0], 1'b0};
          exp_d   = exp_q - 8'd1;
        end else begin
          res_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      ml_q    <= '0;
      ms_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      ml_q    <= ml_d;
      ms_q    <= ms_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign add_res   = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_float_add_seq.sv
// Directed bench for float_add_seq: hand-computed sums, flags, latencies,
// backpressure hold and mid-transaction reset.
module tb_float_add_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] add_res;
  logic        overflow;
  logic        underflow;

  int unsigned checks;
  int unsigned failures;
  int unsigned lat;
  logic [31:0] held;

  float_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .add_res   (add_res),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair across a single rising edge (edge E).
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    operand_A = a;
    operand_B = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operand_A = '0;
    operand_B = '0;
  endtask

  // Count edges after E until out_valid is seen; bounded.
  task automatic wait_done(output int unsigned n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_ovf, input logic exp_unf,
                     input int unsigned exp_lat);
    issue(tag, a, b);
    wait_done(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_res"}, add_res, exp_res);
    check({tag, "_flags"}, {30'd0, overflow, underflow}, {30'd0, exp_ovf, exp_unf});
    retire(tag);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand_A = '0;
    operand_B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_res", add_res, 32'h0);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    rst = 1'b0;

    run("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 3);
    run("one_minus_075", 32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000, 1'b0, 1'b0, 5);
    run("three_minus_three", 32'h4040_0000, 32'hC040_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
    run("zero_plus_neg5", 32'h0000_0000, 32'hC0A0_0000, 32'hC0A0_0000, 1'b0, 1'b0, 1);
    run("inf_plus_one", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1);
    run("max_plus_max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 2);
    run("half_plus_quarter", 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000, 1'b0, 1'b0, 3);

    // Underflow case held under backpressure, with a stray in_valid pulse.
    issue("underflow", 32'h0080_0000, 32'h80FF_FFFF);
    wait_done(lat);
    check("underflow_res", add_res, 32'h0000_0000);
    check("underflow_flags", {30'd0, overflow, underflow}, 32'd1);
    held = add_res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        in_valid  = 1'b1;
        operand_A = 32'h3F80_0000;
        operand_B = 32'h3F80_0000;
      end else begin
        in_valid  = 1'b0;
      end
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_res", add_res, held);
      check("hold_unf", {31'd0, underflow}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    retire("underflow");
    @(negedge clk);
    check("stray_ignored_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of normalisation of 1.0 - 0.75.
    issue("rst_mid_norm", 32'h3F80_0000, 32'hBF40_0000);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_res", add_res, 32'h0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    run("after_rst", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
